// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline types for the hazard sequencer: FSM state encoding and
// the per-stage hold/bubble control bundle.
package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    HZ_RUN  = 1'b0,
    HZ_DROP = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic hold;
    logic bubble;
  } stage_ctl_t;

  localparam int HZ_PC_W  = 64;
  localparam int HZ_RA_W  = 5;
  localparam int HZ_CNT_W = 32;

  // Number of counters kept by the hazard block (stall, flush).
  localparam int HZ_NUM_CNT = 2;

endpackage

// File: rtl/hz_perf_cnt.sv
// Bank of enable-driven free-running performance counters that wrap modulo
// 2^CNT_W. Counter i lives in cnt[i*CNT_W +: CNT_W].
module hz_perf_cnt #(
  parameter int CNT_W = 32,
  parameter int N     = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [N-1:0]       en,
  output logic [N*CNT_W-1:0] cnt
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          cnt_q <= '0;
        end else if (en[gi]) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end

      assign cnt[gi*CNT_W +: CNT_W] = cnt_q;
    end
  endgenerate

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/redirect sequencer for the 5-stage pipeline, including the
// fetch-discard FSM used when a redirect races an in-flight ibus response.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int PC_W  = HZ_PC_W,
  parameter int RA_W  = HZ_RA_W,
  parameter int CNT_W = HZ_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             if_busy,
  input  logic             if_data_ok,
  input  logic             dm_busy,
  input  logic             de_valid,
  input  logic [RA_W-1:0]  de_ra1,
  input  logic [RA_W-1:0]  de_ra2,
  input  logic             ex_valid,
  input  logic             ex_memread,
  input  logic [RA_W-1:0]  ex_dst,
  input  logic             ex_redirect,
  input  logic [PC_W-1:0]  ex_target,
  output logic             hold_f,
  output logic             hold_d,
  output logic             hold_e,
  output logic             hold_m,
  output logic             bubble_d,
  output logic             bubble_e,
  output logic             bubble_w,
  output logic             pc_redirect,
  output logic [PC_W-1:0]  pc_target,
  output logic             if_discard,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_t        state;
  logic [PC_W-1:0]  target_q;

  logic             mem_stall;
  logic             load_use;
  logic             take;
  logic             fetch_pending;

  logic             hold_f_c;
  logic             hold_m_c;
  logic             bubble_w_c;
  stage_ctl_t       ctl_d;
  stage_ctl_t       ctl_e;
  logic             redirect_c;
  logic             discard_c;
  logic             go_drop;
  logic             latch_tgt;
  logic [PC_W-1:0]  tgt_c;

  assign mem_stall = dm_busy;
  assign take      = ex_valid & ex_redirect;
  assign load_use  = ex_valid & ex_memread & de_valid & (ex_dst != '0) &
                     ((ex_dst == de_ra1) | (ex_dst == de_ra2));

  // A response arriving in the same cycle as the redirect is already consumed,
  // so only a still-outstanding request needs to be discarded.
  assign fetch_pending = if_busy & ~if_data_ok;

  always_comb begin
    hold_f_c   = 1'b0;
    hold_m_c   = 1'b0;
    bubble_w_c = 1'b0;
    ctl_d      = '0;
    ctl_e      = '0;
    redirect_c = 1'b0;
    discard_c  = 1'b0;
    go_drop    = 1'b0;
    latch_tgt  = 1'b0;
    tgt_c      = (state == HZ_DROP) ? target_q : ex_target;

    if (state == HZ_DROP) begin
      hold_f_c     = 1'b1;
      ctl_d.bubble = 1'b1;
    end

    if (mem_stall) begin
      hold_f_c   = 1'b1;
      ctl_d.hold = 1'b1;
      ctl_e.hold = 1'b1;
      hold_m_c   = 1'b1;
      bubble_w_c = 1'b1;
    end else if (take) begin
      ctl_d.bubble = 1'b1;
      ctl_e.bubble = 1'b1;
      if (state == HZ_DROP) begin
        latch_tgt = 1'b1;
      end else if (fetch_pending) begin
        latch_tgt = 1'b1;
        go_drop   = 1'b1;
        hold_f_c  = 1'b1;
      end else begin
        redirect_c = 1'b1;
      end
    end else if (load_use) begin
      hold_f_c     = 1'b1;
      ctl_d.hold   = 1'b1;
      ctl_e.bubble = 1'b1;
    end

    if ((state == HZ_DROP) && if_data_ok) begin
      discard_c  = 1'b1;
      redirect_c = 1'b1;
      // A branch resolving in the very cycle the discard completes is the newest.
      if (take && !mem_stall) begin
        tgt_c = ex_target;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= HZ_RUN;
      target_q <= '0;
    end else begin
      if (latch_tgt) begin
        target_q <= ex_target;
      end
      case (state)
        HZ_RUN:  if (go_drop)    state <= HZ_DROP;
        HZ_DROP: if (if_data_ok) state <= HZ_RUN;
        default: state <= HZ_RUN;
      endcase
    end
  end

  assign hold_f      = resetn & hold_f_c;
  assign hold_d      = resetn & ctl_d.hold;
  assign hold_e      = resetn & ctl_e.hold;
  assign hold_m      = resetn & hold_m_c;
  assign bubble_d    = resetn & ctl_d.bubble;
  assign bubble_e    = resetn & ctl_e.bubble;
  assign bubble_w    = resetn & bubble_w_c;
  assign pc_redirect = resetn & redirect_c;
  assign if_discard  = resetn & discard_c;
  assign pc_target   = resetn ? tgt_c : '0;

  logic [HZ_NUM_CNT*CNT_W-1:0] cnt_bus;

  hz_perf_cnt #(
    .CNT_W (CNT_W),
    .N     (HZ_NUM_CNT)
  ) u_perf (
    .clk    (clk),
    .resetn (resetn),
    .en     ({pc_redirect, hold_f}),
    .cnt    (cnt_bus)
  );

  assign stall_cnt = cnt_bus[0 +: CNT_W];
  assign flush_cnt = cnt_bus[CNT_W +: CNT_W];

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/redirect sequencer for the 5-stage RV64 pipeline (fetch, decode, execute, memory, writeback).
- Drives hold/bubble enables for every inter-stage register. Resolves load-use hazards, data-memory waits and taken branches/jumps.
- Owns a small FSM that discards an instruction-fetch response already in flight when a redirect occurs.
- Keeps 32-bit stall and flush performance counters.

Parameters:
PC_W, 64, PC / target width
RA_W, 5, register address width (matches creg_addr_t)
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
if_busy  in  1  ibus request issued, response not yet returned
if_data_ok  in  1  ibus response valid this cycle
dm_busy  in  1  memory stage has dbus access outstanding (data_ok not yet seen)
de_valid  in  1  decode stage holds valid instruction
de_ra1  in  RA_W  decode source 1
de_ra2  in  RA_W  decode source 2
ex_valid  in  1  execute stage valid
ex_memread  in  1  execute instruction is a load
ex_dst  in  RA_W  execute destination
ex_redirect  in  1  execute resolved taken branch / JAL / JALR
ex_target  in  PC_W  redirect target
hold_f  out  1  freeze PC / fetch
hold_d  out  1  freeze F->D register
hold_e  out  1  freeze D->E register
hold_m  out  1  freeze E->M register
bubble_d  out  1  load invalid into F->D register
bubble_e  out  1  load invalid into D->E register
bubble_w  out  1  load invalid into M->W register
pc_redirect  out  1  load PC with pc_target this cycle
pc_target  out  PC_W  redirect PC
if_discard  out  1  drop the if_data_ok response of this cycle
stall_cnt  out  CNT_W  cycles with hold_f asserted
flush_cnt  out  CNT_W  redirects performed

Behaviour:
- Reset (resetn low, async): state=RUN, target_q=0, both counters=0. All outputs 0 while reset is held.
- Hazard terms:
  - mem_stall = dm_busy.
  - load_use = ex_valid & ex_memread & de_valid & ex_dst!=0 & (ex_dst==de_ra1 | ex_dst==de_ra2).
  - take = ex_valid & ex_redirect.
- Priority, evaluated combinationally each cycle:
  1. mem_stall: hold_f, hold_d, hold_e, hold_m =1; bubble_w=1. take and load_use are ignored because EX is frozen, so the branch is seen again next cycle.
  2. take (no mem_stall): bubble_d=1, bubble_e=1. Branch beats load_use (the younger instruction is killed).
     - State RUN, if_busy=0: pc_redirect=1, pc_target=ex_target, flush_cnt+1.
     - State RUN, if_busy=1: latch target_q=ex_target, go to DROP; hold_f=1.
  3. load_use: hold_f=1, hold_d=1, bubble_e=1.
- FSM:
  - RUN: as above.
  - DROP: hold_f=1. bubble_d=1 every cycle, so stale fetch data is never latched. Other stages advance normally unless mem_stall.
    - On if_data_ok: if_discard=1, pc_redirect=1, pc_target=target_q, flush_cnt+1, next state RUN.
    - A second take while in DROP overwrites target_q (newest wins).
    - mem_stall in DROP: holds apply as in priority 1; discard still completes on if_data_ok.
- pc_target=ex_target in RUN and target_q in DROP; it is a don't-care when pc_redirect=0.
- Single-cycle events: if_data_ok in the same cycle as take in RUN counts as if_busy=0; redirect is immediate and no discard occurs.
- Counters: 1-cycle latency, registered. Wrap modulo 2^CNT_W with no saturation. stall_cnt increments every cycle hold_f=1, including DROP cycles.
- Reset asserted in DROP returns to RUN; a pending discard is lost, so the fetch unit is reset together with this block.
- x0 never triggers a load-use stall.

Decomposition:
- Add to the shared pipeline package:
  - enum hz_state_t {HZ_RUN, HZ_DROP};
  - packed struct stage_ctl_t {hold, bubble}, so per-stage outputs can be bundled later.
- One natural sub-module: hz_perf_cnt. It is the enable-driven counter pair and is reused by later perf CSRs.
- The hazard compare stays inline.

Test Plan:
1. Load-use: ex=LD x5, de reads x5 (ra1=5) -> exactly 1 cycle hold_f=hold_d=bubble_e=1; stall_cnt 0->1.
2. Load to x0 with de_ra1=0 -> no stall, all holds 0.
3. Taken branch, if_busy=0, ex_target=0x80000040 -> same cycle pc_redirect=1, pc_target=0x80000040, bubble_d=bubble_e=1; flush_cnt=1.
4. Taken branch with if_busy=1, if_data_ok 3 cycles later:
   - DROP for 3 cycles: hold_f=1, pc_redirect=0.
   - Cycle 4: if_discard=1, pc_redirect=1 with latched target.
   - Back to RUN.
5. dm_busy for 4 cycles together with take and load_use -> holds F/D/E/M and bubble_w for 4 cycles, no redirect. Cycle 5: redirect taken, load_use ignored.
6. resetn pulled low mid-DROP -> outputs 0 asynchronously; after release state=RUN, counters=0.
